// File: rtl/rv32_encoder_pkg.sv
// Purpose: shared RV32I encoder types, immediate range limits and the opcode-to-control lookup.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package rv32_encoder_pkg;

    typedef logic [4:0]  rv32_register_t;
    typedef logic [31:0] rv32_imm_t;
    typedef logic [31:0] rv32_instr_t;

    typedef enum logic [5:0] {
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_FENCE, OP_ECALL, OP_EBREAK,
        OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_CSRRWI, OP_CSRRSI, OP_CSRRCI
    } rv32_opcode_enum_t;

    // SH = immediate shifts (shamt in rs2 slot), CSRI = CSR with zimm in rs1 slot
    typedef enum logic [3:0] {
        FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J,
        FMT_CSR, FMT_CSRI, FMT_FENCE, FMT_SYS, FMT_BAD
    } rv32_enc_fmt_t;

    localparam int IMM_I_MIN = -2048;
    localparam int IMM_I_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;
    localparam int IMM_J_MIN = -(1 << 20);
    localparam int IMM_J_MAX = (1 << 20) - 2;

    typedef struct packed {
        rv32_enc_fmt_t fmt;
        logic [6:0]    opc;
        logic [2:0]    f3;
        logic [6:0]    f7;
    } rv32_enc_ctrl_t;

    // Everything stage 1 hands to stage 2
    typedef struct packed {
        rv32_enc_ctrl_t ctrl;
        logic           trap;
        rv32_register_t rs1;
        rv32_register_t rs2;
        rv32_register_t rd;
        rv32_imm_t      imm;
        logic [4:0]     shamt;
        logic [11:0]    csr;
        logic [4:0]     zimm;
        logic [3:0]     pred;
        logic [3:0]     succ;
    } rv32_enc_s1_t;

    function automatic rv32_enc_ctrl_t rv32_enc_ctrl(input rv32_opcode_enum_t op);
        rv32_enc_ctrl_t c;
        c = '{FMT_BAD, 7'h00, 3'd0, 7'h00};
        case (op)
            OP_LUI:    c = '{FMT_U,     7'h37, 3'd0, 7'h00};
            OP_AUIPC:  c = '{FMT_U,     7'h17, 3'd0, 7'h00};
            OP_JAL:    c = '{FMT_J,     7'h6F, 3'd0, 7'h00};
            OP_JALR:   c = '{FMT_I,     7'h67, 3'd0, 7'h00};
            OP_BEQ:    c = '{FMT_B,     7'h63, 3'd0, 7'h00};
            OP_BNE:    c = '{FMT_B,     7'h63, 3'd1, 7'h00};
            OP_BLT:    c = '{FMT_B,     7'h63, 3'd4, 7'h00};
            OP_BGE:    c = '{FMT_B,     7'h63, 3'd5, 7'h00};
            OP_BLTU:   c = '{FMT_B,     7'h63, 3'd6, 7'h00};
            OP_BGEU:   c = '{FMT_B,     7'h63, 3'd7, 7'h00};
            OP_LB:     c = '{FMT_I,     7'h03, 3'd0, 7'h00};
            OP_LH:     c = '{FMT_I,     7'h03, 3'd1, 7'h00};
            OP_LW:     c = '{FMT_I,     7'h03, 3'd2, 7'h00};
            OP_LBU:    c = '{FMT_I,     7'h03, 3'd4, 7'h00};
            OP_LHU:    c = '{FMT_I,     7'h03, 3'd5, 7'h00};
            OP_SB:     c = '{FMT_S,     7'h23, 3'd0, 7'h00};
            OP_SH:     c = '{FMT_S,     7'h23, 3'd1, 7'h00};
            OP_SW:     c = '{FMT_S,     7'h23, 3'd2, 7'h00};
            OP_ADDI:   c = '{FMT_I,     7'h13, 3'd0, 7'h00};
            OP_SLTI:   c = '{FMT_I,     7'h13, 3'd2, 7'h00};
            OP_SLTIU:  c = '{FMT_I,     7'h13, 3'd3, 7'h00};
            OP_XORI:   c = '{FMT_I,     7'h13, 3'd4, 7'h00};
            OP_ORI:    c = '{FMT_I,     7'h13, 3'd6, 7'h00};
            OP_ANDI:   c = '{FMT_I,     7'h13, 3'd7, 7'h00};
            OP_SLLI:   c = '{FMT_SH,    7'h13, 3'd1, 7'h00};
            OP_SRLI:   c = '{FMT_SH,    7'h13, 3'd5, 7'h00};
            OP_SRAI:   c = '{FMT_SH,    7'h13, 3'd5, 7'h20};
            OP_ADD:    c = '{FMT_R,     7'h33, 3'd0, 7'h00};
            OP_SUB:    c = '{FMT_R,     7'h33, 3'd0, 7'h20};
            OP_SLL:    c = '{FMT_R,     7'h33, 3'd1, 7'h00};
            OP_SLT:    c = '{FMT_R,     7'h33, 3'd2, 7'h00};
            OP_SLTU:   c = '{FMT_R,     7'h33, 3'd3, 7'h00};
            OP_XOR:    c = '{FMT_R,     7'h33, 3'd4, 7'h00};
            OP_SRL:    c = '{FMT_R,     7'h33, 3'd5, 7'h00};
            OP_SRA:    c = '{FMT_R,     7'h33, 3'd5, 7'h20};
            OP_OR:     c = '{FMT_R,     7'h33, 3'd6, 7'h00};
            OP_AND:    c = '{FMT_R,     7'h33, 3'd7, 7'h00};
            OP_FENCE:  c = '{FMT_FENCE, 7'h0F, 3'd0, 7'h00};
            OP_ECALL:  c = '{FMT_SYS,   7'h73, 3'd0, 7'h00};
            OP_EBREAK: c = '{FMT_SYS,   7'h73, 3'd0, 7'h00};
            OP_CSRRW:  c = '{FMT_CSR,   7'h73, 3'd1, 7'h00};
            OP_CSRRS:  c = '{FMT_CSR,   7'h73, 3'd2, 7'h00};
            OP_CSRRC:  c = '{FMT_CSR,   7'h73, 3'd3, 7'h00};
            OP_CSRRWI: c = '{FMT_CSRI,  7'h73, 3'd5, 7'h00};
            OP_CSRRSI: c = '{FMT_CSRI,  7'h73, 3'd6, 7'h00};
            OP_CSRRCI: c = '{FMT_CSRI,  7'h73, 3'd7, 7'h00};
            default:   c = '{FMT_BAD,   7'h00, 3'd0, 7'h00};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rv32_encoder_imm_pack.sv
// Purpose: overlays the immediate-like fields (imm, shamt, csr, zimm, fence sets) onto a 32-bit word.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module rv32_encoder_imm_pack
    import rv32_encoder_pkg::*;
(
    input  rv32_enc_fmt_t fmt,
    input  logic [31:0]   imm,
    input  logic [4:0]    shamt,
    input  logic [11:0]   csr,
    input  logic [4:0]    zimm,
    input  logic [3:0]    pred,
    input  logic [3:0]    succ,
    output logic [31:0]   field
);

    // Scatter the immediate bits into their format-specific slots; all other bits stay zero
    always_comb begin
        field = '0;
        case (fmt)
            FMT_I:  field[31:20] = imm[11:0];
            FMT_SH: field[24:20] = shamt;
            FMT_S: begin
                field[31:25] = imm[11:5];
                field[11:7]  = imm[4:0];
            end
            FMT_B: begin
                field[31]    = imm[12];
                field[30:25] = imm[10:5];
                field[11:8]  = imm[4:1];
                field[7]     = imm[11];
            end
            FMT_U:  field[31:12] = imm[31:12];
            FMT_J: begin
                field[31]    = imm[20];
                field[30:21] = imm[10:1];
                field[20]    = imm[11];
                field[19:12] = imm[19:12];
            end
            // SYS carries funct12 (0 = ECALL, 1 = EBREAK) in the csr slot
            FMT_CSR, FMT_SYS: field[31:20] = csr;
            FMT_CSRI: begin
                field[31:20] = csr;
                field[19:15] = zimm;
            end
            FMT_FENCE: begin
                field[27:24] = pred;
                field[23:20] = succ;
            end
            default: field = '0;
        endcase
    end

endmodule

// File: rtl/rv32_encoder.sv
// Purpose: packs decoded RV32I fields into a 32-bit instruction word, flagging illegal encodes.
// Latency: 2 cycles from input handshake to out_valid; 1 word/cycle when unstalled.
// Backpressure: in_ready combinational from out_ready; both stages hold while out_ready is low.
module rv32_encoder
    import rv32_encoder_pkg::*;
#(
    parameter int          CNT_W      = 32,
    parameter logic [31:0] TRAP_INSTR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  rv32_opcode_enum_t rv_opcode,
    input  rv32_register_t    rv_rs1,
    input  rv32_register_t    rv_rs2,
    input  rv32_register_t    rv_rd,
    input  rv32_imm_t         rv_imm,
    input  logic [4:0]        rv_shamt,
    input  logic [11:0]       rv_csr,
    input  logic [4:0]        rv_zimm,
    input  logic [3:0]        rv_fence_pred,
    input  logic [3:0]        rv_fence_succ,
    output logic              out_valid,
    input  logic              out_ready,
    output rv32_instr_t       instr,
    output logic              enc_trap,
    output logic [CNT_W-1:0]  instr_cnt,
    output logic [CNT_W-1:0]  trap_cnt
);

    logic               s1_v;
    logic               s2_v;
    logic               s1_adv;
    logic               deliver;
    rv32_enc_s1_t       s1_d;
    rv32_enc_s1_t       s1_q;
    logic signed [31:0] imm_s;
    logic [31:0]        imm_field;
    logic [31:0]        pack_word;

    assign s1_adv    = !s2_v || out_ready;
    assign in_ready  = !s1_v || s1_adv;
    assign out_valid = s2_v;
    assign deliver   = s2_v && out_ready && !flush;
    assign imm_s     = $signed(rv_imm);

    // Stage 1: classify the opcode and range-check the immediate for that format
    always_comb begin
        s1_d       = '0;
        s1_d.ctrl  = rv32_enc_ctrl(rv_opcode);
        s1_d.rs1   = rv_rs1;
        s1_d.rs2   = rv_rs2;
        s1_d.rd    = rv_rd;
        s1_d.imm   = rv_imm;
        s1_d.shamt = rv_shamt;
        s1_d.csr   = rv_csr;
        s1_d.zimm  = rv_zimm;
        s1_d.pred  = rv_fence_pred;
        s1_d.succ  = rv_fence_succ;
        if (s1_d.ctrl.fmt == FMT_SYS) begin
            s1_d.csr = {11'd0, rv_opcode == OP_EBREAK};
        end
        case (s1_d.ctrl.fmt)
            FMT_I, FMT_S: s1_d.trap = (imm_s < IMM_I_MIN) || (imm_s > IMM_I_MAX);
            FMT_B:        s1_d.trap = (imm_s < IMM_B_MIN) || (imm_s > IMM_B_MAX) || rv_imm[0];
            FMT_J:        s1_d.trap = (imm_s < IMM_J_MIN) || (imm_s > IMM_J_MAX) || rv_imm[0];
            FMT_U:        s1_d.trap = |rv_imm[11:0];
            FMT_BAD:      s1_d.trap = 1'b1;
            default:      s1_d.trap = 1'b0;
        endcase
    end

    rv32_encoder_imm_pack u_imm_pack (
        .fmt   (s1_q.ctrl.fmt),
        .imm   (s1_q.imm),
        .shamt (s1_q.shamt),
        .csr   (s1_q.csr),
        .zimm  (s1_q.zimm),
        .pred  (s1_q.pred),
        .succ  (s1_q.succ),
        .field (imm_field)
    );

    // Stage 2: lay register/funct fields over the immediate overlay, or substitute the trap word
    always_comb begin
        pack_word      = imm_field;
        pack_word[6:0] = s1_q.ctrl.opc;
        if (s1_q.ctrl.fmt != FMT_U && s1_q.ctrl.fmt != FMT_J) begin
            pack_word[14:12] = s1_q.ctrl.f3;
        end
        case (s1_q.ctrl.fmt)
            FMT_R: begin
                pack_word[31:25] = s1_q.ctrl.f7;
                pack_word[24:20] = s1_q.rs2;
                pack_word[19:15] = s1_q.rs1;
                pack_word[11:7]  = s1_q.rd;
            end
            FMT_SH: begin
                pack_word[31:25] = s1_q.ctrl.f7;
                pack_word[19:15] = s1_q.rs1;
                pack_word[11:7]  = s1_q.rd;
            end
            FMT_I, FMT_CSR, FMT_FENCE: begin
                pack_word[19:15] = s1_q.rs1;
                pack_word[11:7]  = s1_q.rd;
            end
            FMT_S, FMT_B: begin
                pack_word[24:20] = s1_q.rs2;
                pack_word[19:15] = s1_q.rs1;
            end
            FMT_U, FMT_J, FMT_CSRI: pack_word[11:7] = s1_q.rd;
            default: pack_word = pack_word;
        endcase
        if (s1_q.trap) begin
            pack_word = TRAP_INSTR;
        end
    end

    // Pipeline registers; flush empties both stages and wins over any handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v     <= 1'b0;
            s2_v     <= 1'b0;
            s1_q     <= '0;
            instr    <= '0;
            enc_trap <= 1'b0;
        end else if (flush) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            if (s1_adv) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    instr    <= pack_word;
                    enc_trap <= s1_q.trap;
                end
            end
            if (in_ready) begin
                s1_v <= in_valid;
                if (in_valid) begin
                    s1_q <= s1_d;
                end
            end
        end
    end

    // Delivery counters, wrapping; a trapped word bumps both
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_cnt <= '0;
            trap_cnt  <= '0;
        end else if (deliver) begin
            instr_cnt <= instr_cnt + CNT_W'(1);
            if (enc_trap) begin
                trap_cnt <= trap_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rv32_encoder.sv
// Purpose: self-checking bench for rv32_encoder: directed ISA vectors, stalls, flush, reset, random stream.
// Latency: checks the 2-cycle accept-to-output timing explicitly.
// Backpressure: drives randomized and scripted out_ready, checks hold-stable and in_ready.
module tb_rv32_encoder;
    import rv32_encoder_pkg::*;

    typedef struct packed {
        rv32_opcode_enum_t op;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [31:0]       imm;
        logic [4:0]        shamt;
        logic [11:0]       csr;
        logic [4:0]        zimm;
        logic [3:0]        pred;
        logic [3:0]        succ;
    } bundle_t;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    rv32_opcode_enum_t rv_opcode;
    logic [4:0]        rv_rs1, rv_rs2, rv_rd, rv_shamt, rv_zimm;
    logic [31:0]       rv_imm;
    logic [11:0]       rv_csr;
    logic [3:0]        rv_fence_pred, rv_fence_succ;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       instr;
    logic              enc_trap;
    logic [31:0]       instr_cnt;
    logic [31:0]       trap_cnt;

    int checks = 0;
    int errors = 0;
    int exp_icnt = 0;
    int exp_tcnt = 0;

    rv32_encoder #(.CNT_W(32), .TRAP_INSTR(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .rv_opcode(rv_opcode), .rv_rs1(rv_rs1), .rv_rs2(rv_rs2), .rv_rd(rv_rd),
        .rv_imm(rv_imm), .rv_shamt(rv_shamt), .rv_csr(rv_csr), .rv_zimm(rv_zimm),
        .rv_fence_pred(rv_fence_pred), .rv_fence_succ(rv_fence_succ),
        .out_valid(out_valid), .out_ready(out_ready),
        .instr(instr), .enc_trap(enc_trap),
        .instr_cnt(instr_cnt), .trap_cnt(trap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model: RV32I field layouts ----------------
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
        return (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(opc);
    endfunction

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(opc);
    endfunction

    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
             | ((imm & 32'h1F) << 7) | 32'h23;
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20)
             | (32'(rs1) << 15) | (32'(f3) << 12) | (((imm >> 1) & 32'hF) << 8)
             | (((imm >> 11) & 32'h1) << 7) | 32'h63;
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20)
             | (((imm >> 12) & 32'hFF) << 12) | (32'(rd) << 7) | 32'h6F;
    endfunction

    function automatic logic [32:0] model(input bundle_t b);
        logic [31:0] w;
        logic        t;
        int          v;
        bit          i12;
        v   = $signed(b.imm);
        i12 = (v >= -2048) && (v <= 2047);
        w   = 32'h0;
        t   = 1'b0;
        case (b.op)
            OP_LUI:    begin t = (b.imm % 4096) != 0; w = (b.imm & 32'hFFFFF000) | (32'(b.rd) << 7) | 32'h37; end
            OP_AUIPC:  begin t = (b.imm % 4096) != 0; w = (b.imm & 32'hFFFFF000) | (32'(b.rd) << 7) | 32'h17; end
            OP_JAL:    begin t = v < -1048576 || v > 1048574 || (v % 2) != 0; w = enc_j(b.imm, b.rd); end
            OP_JALR:   begin t = !i12; w = enc_i(b.imm, b.rs1, 3'd0, b.rd, 7'h67); end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                t = v < -4096 || v > 4094 || (v % 2) != 0;
                case (b.op)
                    OP_BEQ:  w = enc_b(b.imm, b.rs2, b.rs1, 3'd0);
                    OP_BNE:  w = enc_b(b.imm, b.rs2, b.rs1, 3'd1);
                    OP_BLT:  w = enc_b(b.imm, b.rs2, b.rs1, 3'd4);
                    OP_BGE:  w = enc_b(b.imm, b.rs2, b.rs1, 3'd5);
                    OP_BLTU: w = enc_b(b.imm, b.rs2, b.rs1, 3'd6);
                    default: w = enc_b(b.imm, b.rs2, b.rs1, 3'd7);
                endcase
            end
            OP_LB:     begin t = !i12; w = enc_i(b.imm, b.rs1, 3'd0, b.rd, 7'h03); end
            OP_LH:     begin t = !i12; w = enc_i(b.imm, b.rs1, 3'd1, b.rd, 7'h03); end
            OP_LW:     begin t = !i12; w = enc_i(b.imm, b.rs1, 3'd2, b.rd, 7'h03); end
            OP_LBU:    begin t = !i12; w = enc_i(b.imm, b.rs1, 3'd4, b.rd, 7'h03); end
            OP_LHU:    begin t = !i12; w = enc_i(b.imm, b.rs1, 3'd5, b.rd, 7'h03); end
            OP_SB:     begin t = !i12; w = enc_s(b.imm, b.rs2, b.rs1, 3'd0); end
            OP_SH:     begin t = !i12; w = enc_s(b.imm, b.rs2, b.rs1, 3'd1); end
            OP_SW:     begin t = !i12; w = enc_s(b.imm, b.rs2, b.rs1, 3'd2); end
            OP_ADDI:   begin t = !i12; w = enc_i(b.imm, b.rs1, 3'd0, b.rd, 7'h13); end
            OP_SLTI:   begin t = !i12; w = enc_i(b.imm, b.rs1, 3'd2, b.rd, 7'h13); end
            OP_SLTIU:  begin t = !i12; w = enc_i(b.imm, b.rs1, 3'd3, b.rd, 7'h13); end
            OP_XORI:   begin t = !i12; w = enc_i(b.imm, b.rs1, 3'd4, b.rd, 7'h13); end
            OP_ORI:    begin t = !i12; w = enc_i(b.imm, b.rs1, 3'd6, b.rd, 7'h13); end
            OP_ANDI:   begin t = !i12; w = enc_i(b.imm, b.rs1, 3'd7, b.rd, 7'h13); end
            OP_SLLI:   w = enc_r(7'h00, b.shamt, b.rs1, 3'd1, b.rd, 7'h13);
            OP_SRLI:   w = enc_r(7'h00, b.shamt, b.rs1, 3'd5, b.rd, 7'h13);
            OP_SRAI:   w = enc_r(7'h20, b.shamt, b.rs1, 3'd5, b.rd, 7'h13);
            OP_ADD:    w = enc_r(7'h00, b.rs2, b.rs1, 3'd0, b.rd, 7'h33);
            OP_SUB:    w = enc_r(7'h20, b.rs2, b.rs1, 3'd0, b.rd, 7'h33);
            OP_SLL:    w = enc_r(7'h00, b.rs2, b.rs1, 3'd1, b.rd, 7'h33);
            OP_SLT:    w = enc_r(7'h00, b.rs2, b.rs1, 3'd2, b.rd, 7'h33);
            OP_SLTU:   w = enc_r(7'h00, b.rs2, b.rs1, 3'd3, b.rd, 7'h33);
            OP_XOR:    w = enc_r(7'h00, b.rs2, b.rs1, 3'd4, b.rd, 7'h33);
            OP_SRL:    w = enc_r(7'h00, b.rs2, b.rs1, 3'd5, b.rd, 7'h33);
            OP_SRA:    w = enc_r(7'h20, b.rs2, b.rs1, 3'd5, b.rd, 7'h33);
            OP_OR:     w = enc_r(7'h00, b.rs2, b.rs1, 3'd6, b.rd, 7'h33);
            OP_AND:    w = enc_r(7'h00, b.rs2, b.rs1, 3'd7, b.rd, 7'h33);
            OP_FENCE:  w = enc_i({24'h0, b.pred, b.succ}, b.rs1, 3'd0, b.rd, 7'h0F);
            OP_ECALL:  w = 32'h0000_0073;
            OP_EBREAK: w = 32'h0010_0073;
            OP_CSRRW:  w = enc_i({20'h0, b.csr}, b.rs1,  3'd1, b.rd, 7'h73);
            OP_CSRRS:  w = enc_i({20'h0, b.csr}, b.rs1,  3'd2, b.rd, 7'h73);
            OP_CSRRC:  w = enc_i({20'h0, b.csr}, b.rs1,  3'd3, b.rd, 7'h73);
            OP_CSRRWI: w = enc_i({20'h0, b.csr}, b.zimm, 3'd5, b.rd, 7'h73);
            OP_CSRRSI: w = enc_i({20'h0, b.csr}, b.zimm, 3'd6, b.rd, 7'h73);
            OP_CSRRCI: w = enc_i({20'h0, b.csr}, b.zimm, 3'd7, b.rd, 7'h73);
            default:   t = 1'b1;
        endcase
        if (t) w = 32'h0;
        return {t, w};
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic bundle_t mk(input rv32_opcode_enum_t op, input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic [31:0] imm);
        bundle_t b;
        b = '0;
        b.op = op; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.imm = imm;
        return b;
    endfunction

    function automatic bundle_t rand_bundle();
        bundle_t     b;
        logic [31:0] r;
        r       = $urandom;
        b.op    = rv32_opcode_enum_t'(6'($urandom_range(0, 50)));
        b.rs1   = 5'($urandom);
        b.rs2   = 5'($urandom);
        b.rd    = 5'($urandom);
        b.shamt = 5'($urandom);
        b.csr   = 12'($urandom);
        b.zimm  = 5'($urandom);
        b.pred  = 4'($urandom);
        b.succ  = 4'($urandom);
        case ($urandom_range(0, 3))
            0:       b.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            1:       b.imm = {{11{r[20]}}, r[20:1], 1'b0};
            2:       b.imm = {r[31:12], 12'h000};
            default: b.imm = r;
        endcase
        return b;
    endfunction

    task automatic drive(input bundle_t b);
        rv_opcode = b.op; rv_rs1 = b.rs1; rv_rs2 = b.rs2; rv_rd = b.rd; rv_imm = b.imm;
        rv_shamt = b.shamt; rv_csr = b.csr; rv_zimm = b.zimm; rv_fence_pred = b.pred; rv_fence_succ = b.succ;
    endtask

    // One isolated word: checks 2-cycle latency, the word, the trap flag and the counters after delivery
    task automatic directed(input string tag, input bundle_t b, input logic [31:0] exp_w, input logic exp_t);
        out_ready = 1'b1;
        drive(b);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_lat2"}, 32'(out_valid), 32'd1);
        chk({tag, "_instr"}, instr, exp_w);
        chk({tag, "_trap"}, 32'(enc_trap), 32'(exp_t));
        @(posedge clk); #1;
        exp_icnt++;
        if (exp_t) exp_tcnt++;
        chk({tag, "_icnt"}, instr_cnt, 32'(exp_icnt));
        chk({tag, "_tcnt"}, trap_cnt, 32'(exp_tcnt));
    endtask

    // Streams nwords random bundles; scripted=1 holds out_ready low on stream cycles 3..5
    task automatic run_stream(input string tag, input int nwords, input bit scripted);
        bundle_t     b;
        logic [32:0] q[$];
        logic [32:0] e;
        int          sent, got, cyc;
        bit          hold_v, acc;
        logic [31:0] hold_w;
        logic        hold_t;
        sent = 0; got = 0; cyc = 0; hold_v = 1'b0;
        in_valid = 1'b0;
        while (got < nwords && cyc < 5000) begin
            out_ready = scripted ? !(cyc >= 3 && cyc <= 5) : ($urandom_range(0, 3) != 0);
            if (!in_valid && sent < nwords && (scripted || $urandom_range(0, 4) != 0)) begin
                b = rand_bundle();
                drive(b);
                in_valid = 1'b1;
            end
            @(negedge clk);
            if (hold_v) begin
                chk({tag, "_hold_vld"}, 32'(out_valid), 32'd1);
                chk({tag, "_hold_instr"}, instr, hold_w);
                chk({tag, "_hold_trap"}, 32'(enc_trap), 32'(hold_t));
            end
            chk({tag, "_in_ready"}, 32'(in_ready), 32'(!(q.size() == 2 && !out_ready)));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk({tag, "_spurious"}, 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk({tag, "_instr"}, instr, e[31:0]);
                    chk({tag, "_trap"}, 32'(enc_trap), 32'(e[32]));
                    exp_icnt++;
                    if (e[32]) exp_tcnt++;
                end
                got++;
            end
            hold_v = out_valid && !out_ready;
            hold_w = instr;
            hold_t = enc_trap;
            acc = in_valid && in_ready;
            if (acc) begin
                q.push_back(model(b));
                sent++;
            end
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk({tag, "_delivered"}, 32'(got), 32'(nwords));
        chk({tag, "_leftover"}, 32'(q.size()), 32'd0);
        chk({tag, "_icnt"}, instr_cnt, 32'(exp_icnt));
        chk({tag, "_tcnt"}, trap_cnt, 32'(exp_tcnt));
    endtask

    bundle_t     tb_b;
    logic [31:0] save_icnt;
    logic [31:0] save_tcnt;

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive('0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_trap", 32'(enc_trap), 32'd0);
        chk("rst_icnt", instr_cnt, 32'd0);
        chk("rst_tcnt", trap_cnt, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Directed ISA vectors
        directed("addi", mk(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5), 32'h0050_0093, 1'b0);
        directed("add", mk(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0), 32'h0020_81B3, 1'b0);
        directed("sw", mk(OP_SW, 5'd0, 5'd1, 5'd2, 32'd8), 32'h0020_A423, 1'b0);
        directed("lui", mk(OP_LUI, 5'd5, 5'd0, 5'd0, 32'h1234_5000), 32'h1234_52B7, 1'b0);
        directed("beq_m4", mk(OP_BEQ, 5'd0, 5'd0, 5'd0, -32'sd4), 32'hFE00_0EE3, 1'b0);
        directed("beq_m3", mk(OP_BEQ, 5'd0, 5'd0, 5'd0, -32'sd3), 32'h0000_0000, 1'b1);
        directed("addi_2048", mk(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd2048), 32'h0000_0000, 1'b1);
        directed("addi_m2048", mk(OP_ADDI, 5'd1, 5'd0, 5'd0, -32'sd2048), 32'h8000_0093, 1'b0);
        directed("add_x0", mk(OP_ADD, 5'd0, 5'd1, 5'd2, 32'd0), 32'h0020_8033, 1'b0);
        tb_b = mk(OP_SRAI, 5'd1, 5'd2, 5'd0, 32'hDEAD_BEEF);
        tb_b.shamt = 5'd3;
        directed("srai", tb_b, 32'h4031_5093, 1'b0);
        directed("ebreak", mk(OP_EBREAK, 5'd7, 5'd9, 5'd0, 32'd0), 32'h0010_0073, 1'b0);
        directed("bad_enum", mk(rv32_opcode_enum_t'(6'd55), 5'd1, 5'd2, 5'd3, 32'd0), 32'h0000_0000, 1'b1);

        // Back-to-back 8 words with a 3-cycle output stall
        run_stream("b2b", 8, 1'b1);

        // Flush with both stages full and a simultaneous input+output handshake
        out_ready = 1'b0;
        drive(rand_bundle()); in_valid = 1'b1;
        @(posedge clk); #1;
        drive(rand_bundle());
        @(posedge clk); #1;
        chk("flush_full", 32'(out_valid), 32'd1);
        drive(rand_bundle());
        out_ready = 1'b1;
        flush = 1'b1;
        #1;
        chk("flush_in_hs", 32'(in_ready), 32'd1);
        save_icnt = instr_cnt;
        save_tcnt = trap_cnt;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_vld", 32'(out_valid), 32'd0);
        chk("flush_icnt", instr_cnt, save_icnt);
        chk("flush_tcnt", trap_cnt, save_tcnt);
        @(posedge clk); #1;
        chk("flush_vld2", 32'(out_valid), 32'd0);

        // Random traffic with random backpressure against the model
        run_stream("rand", 300, 1'b0);

        // Reset in the middle of a stream
        out_ready = 1'b0;
        drive(rand_bundle()); in_valid = 1'b1;
        @(posedge clk); #1;
        drive(rand_bundle());
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("mrst_vld", 32'(out_valid), 32'd0);
        chk("mrst_instr", instr, 32'd0);
        chk("mrst_icnt", instr_cnt, 32'd0);
        chk("mrst_tcnt", trap_cnt, 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mrst_after", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
